// File: rtl/status_command_decoder_pkg.sv
// status_cmd_pkg: shared widths, field offsets, opcodes, response bytes and FSM encoding for the command decoder.
package status_cmd_pkg;
  localparam int WORD_SIZE = 32;
  localparam int INPUT_DATA_SIZE = 52;
  localparam int SIZE_WORD = 3;
  localparam int NUM_REGS = 8;
  localparam int REG_ADDR_W = 3;
  localparam int OP_LSB = 48;
  localparam int ADDR_LSB = 32;
  localparam int CSUM_LSB = 44;
  localparam int DATA_LSB = 0;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ = 4'h2;
  localparam logic [3:0] OP_STATUS = 4'h3;
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SEND, S_WAIT_HI, S_WAIT_LO} state_t;
  // XOR of every nibble except the checksum nibble itself
  function automatic logic [3:0] nib_xor(input logic [INPUT_DATA_SIZE-1:0] cv);
    nib_xor = '0;
    for (int i = 0; i < INPUT_DATA_SIZE / 4; i++)
      if (i != CSUM_LSB / 4) nib_xor ^= cv[i*4+:4];
  endfunction
endpackage

// File: rtl/status_command_decoder_if.sv
// status_command_decoder_if: command-in / response-out handshake between the UART sender and the decoder.
interface status_command_decoder_if;
  import status_cmd_pkg::*;
  logic [INPUT_DATA_SIZE-1:0] control_value;
  logic valid_control_value;
  logic busy;
  logic [WORD_SIZE-1:0] data_to_send;
  logic [SIZE_WORD-1:0] size_of_data;
  logic valid_data;
  modport master (output control_value, valid_control_value, busy, input data_to_send, size_of_data, valid_data);
  modport slave (input control_value, valid_control_value, busy, output data_to_send, size_of_data, valid_data);
endinterface

// File: rtl/status_command_decoder_regfile.sv
// status_cmd_regfile: NUM_REGS x WORD_SIZE register file with one write port, one-hot strobe and flat output.
module status_cmd_regfile import status_cmd_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [NUM_REGS-1:0] strobe,
  output logic [NUM_REGS*WORD_SIZE-1:0] flat
);
  logic [WORD_SIZE-1:0] regs [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (we) regs[addr] <= wdata;
  assign rdata = regs[addr];
  assign strobe = {{(NUM_REGS-1){1'b0}}, we} << addr;
  genvar i;
  for (i = 0; i < NUM_REGS; i++) begin : g_flat
    assign flat[i*WORD_SIZE+:WORD_SIZE] = regs[i];
  end
endmodule

// File: rtl/status_command_decoder.sv
// status_command_decoder: executes WRITE/READ/STATUS commands from the UART sender and returns ACK/NAK/data responses.
// Define STATUS_CMD_CHECKSUM_EN to require cv[47:44] to be the XOR of the other nibbles.
module status_command_decoder import status_cmd_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  status_command_decoder_if.slave bus,
  input  logic [15:0] status_in,
  output logic [NUM_REGS*WORD_SIZE-1:0] reg_file_out,
  output logic [NUM_REGS-1:0] reg_write_strobe,
  output logic cmd_busy
);
  state_t state, state_n;
  logic [INPUT_DATA_SIZE-1:0] pend_cmd, cmd;
  logic pend_vld, take, drop, addr_ok, sum_ok, nak, wr;
  logic [1:0] tmo;
  logic [7:0] ovf_cnt, nak_cnt;
  logic [3:0] op;
  logic [WORD_SIZE-1:0] rdata;
  assign op = cmd[OP_LSB+:4];
  assign take = state == S_IDLE && pend_vld;
  // a pulse landing while IDLE drains the buffer is kept, not counted as overflow
  assign drop = bus.valid_control_value && pend_vld && !take;
`ifdef STATUS_CMD_CHECKSUM_EN
  assign sum_ok = cmd[CSUM_LSB+:4] == nib_xor(cmd);
`else
  logic unused_sum;
  assign unused_sum = ^cmd[CSUM_LSB+:4];
  assign sum_ok = 1'b1;
`endif
  assign addr_ok = cmd[ADDR_LSB+REG_ADDR_W+:12-REG_ADDR_W] == '0;
  assign nak = !sum_ok || !(op == OP_STATUS || ((op == OP_WRITE || op == OP_READ) && addr_ok));
  assign wr = state == S_EXEC && op == OP_WRITE && !nak;
  assign bus.valid_data = state == S_SEND;
  assign cmd_busy = state != S_IDLE || pend_vld;
  status_cmd_regfile u_regfile (
    .clk(clk), .rst_n(rst_n), .we(wr), .addr(cmd[ADDR_LSB+:REG_ADDR_W]), .wdata(cmd[DATA_LSB+:WORD_SIZE]),
    .rdata(rdata), .strobe(reg_write_strobe), .flat(reg_file_out)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = pend_vld ? S_EXEC : S_IDLE;
      S_EXEC:    state_n = S_SEND;
      S_SEND:    state_n = S_WAIT_HI;
      S_WAIT_HI: state_n = bus.busy ? S_WAIT_LO : (tmo == 2'd3 ? S_IDLE : S_WAIT_HI);
      S_WAIT_LO: state_n = bus.busy ? S_WAIT_LO : S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      tmo <= '0;
      pend_vld <= 1'b0;
      pend_cmd <= '0;
      cmd <= '0;
      ovf_cnt <= '0;
      nak_cnt <= '0;
      bus.data_to_send <= '0;
      bus.size_of_data <= '0;
    end else begin
      state <= state_n;
      tmo <= state == S_WAIT_HI ? tmo + 2'd1 : 2'd0;
      pend_vld <= (bus.valid_control_value && !drop) ? 1'b1 : take ? 1'b0 : pend_vld;
      if (bus.valid_control_value && !drop) pend_cmd <= bus.control_value;
      if (take) cmd <= pend_cmd;
      ovf_cnt <= ovf_cnt + {7'd0, drop && ovf_cnt != 8'hFF};
      if (state == S_EXEC) begin
        nak_cnt <= nak_cnt + {7'd0, nak && nak_cnt != 8'hFF};
        bus.data_to_send <= nak ? WORD_SIZE'(NAK_BYTE) : op == OP_WRITE ? WORD_SIZE'(ACK_BYTE) :
                            op == OP_READ ? rdata : {ovf_cnt, nak_cnt, status_in};
        bus.size_of_data <= (nak || op == OP_WRITE) ? SIZE_WORD'(1) : SIZE_WORD'(4);
      end
    end
endmodule
